amm_read_burst_gen: RTL and testbench

// Read-side transmitter of the memory checker, directly upstream of the compare stage. Splits a byte-addressed check command into AMM burst reads.
// Per accepted burst it pushes one compare descriptor (address, word count, byte offsets, data pattern seed, mode) into the compare stage.

---
 rtl/amm_read_burst_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_amm_read_burst_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/amm_read_burst_gen.sv
// AMM read burst generator: splits byte-addressed check commands into bounded bursts and feeds compare descriptors.
// Define BURST_ALIGN_EN to keep every burst inside one MAX_BURST-word aligned block.
module amm_read_burst_gen #(
    parameter int AMM_DATA_W   = 64,
    parameter int AMM_ADDR_W   = 31,
    parameter int AMM_BURST_W  = 5,
    parameter int CMD_LEN_W    = 32,
    parameter int MAX_INFLIGHT = 64,
    localparam int DATA_B      = AMM_DATA_W / 8,
    localparam int OFF_W       = $clog2(DATA_B),
    localparam int BA_W        = AMM_ADDR_W + OFF_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_start_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [BA_W-1:0]        cmd_addr_i,
    input  logic [CMD_LEN_W-1:0]   cmd_len_i,
    input  logic [7:0]             cmd_ptrn_i,
    input  logic                   cmd_rnd_i,
    output logic                   read_o,
    output logic [AMM_ADDR_W-1:0]  address_o,
    output logic [AMM_BURST_W-1:0] burstcount_o,
    input  logic                   waitrequest_i,
    input  logic                   readdatavalid_i,
    output logic                   cmp_en_o,
    output logic [AMM_ADDR_W-1:0]  cmp_start_addr_o,
    output logic [AMM_BURST_W-2:0] cmp_words_cnt_o,
    output logic [OFF_W-1:0]       cmp_start_off_o,
    output logic [OFF_W-1:0]       cmp_end_off_o,
    output logic [7:0]             cmp_ptrn_o,
    output logic                   cmp_rnd_o,
    input  logic                   cmp_error_i,
    output logic                   done_o,
    output logic                   busy_o
);
    localparam int MAX_BURST = 2 ** (AMM_BURST_W - 1);
    localparam int CNT_W     = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [2:0] {IDLE_S, CALC_S, ISSUE_S, SEED_S, ERROR_S} state_e;

    state_e                 state_q, state_d;
    logic [AMM_ADDR_W-1:0]  addr_q, addr_d;
    logic [OFF_W-1:0]       off_q, off_d;
    logic [OFF_W-1:0]       end_off_q, end_off_d;
    logic [CMD_LEN_W-1:0]   len_q, len_d;
    logic [CMD_LEN_W-1:0]   rem_q, rem_d;
    logic [7:0]             ptrn_q, ptrn_d;
    logic                   rnd_q, rnd_d;
    logic                   first_q, first_d;
    logic [CNT_W-1:0]       inflight_q, inflight_d;
    logic [AMM_BURST_W-1:0] seed_cnt_q, seed_cnt_d;
    logic                   err_pend_q, err_pend_d;
    logic                   done_q, done_d;

    logic [CMD_LEN_W:0]     last_byte;
    logic [CMD_LEN_W-1:0]   total_words;
    logic [AMM_BURST_W-1:0] rem_clip;
    logic [AMM_BURST_W-1:0] burst;
    logic                   last_burst;
    logic                   issue_ok;
    logic                   accept;
    logic                   err_now;

    assign last_byte   = (CMD_LEN_W+1)'(off_q) + (CMD_LEN_W+1)'(len_q) - (CMD_LEN_W+1)'(1);
    assign total_words = CMD_LEN_W'(last_byte >> OFF_W) + CMD_LEN_W'(1);
    assign rem_clip    = (rem_q >= CMD_LEN_W'(MAX_BURST)) ? AMM_BURST_W'(MAX_BURST)
                                                          : rem_q[AMM_BURST_W-1:0];
`ifdef BURST_ALIGN_EN
    logic [AMM_BURST_W-1:0] room;
    assign room  = AMM_BURST_W'(MAX_BURST) - {1'b0, addr_q[AMM_BURST_W-2:0]};
    assign burst = (room < rem_clip) ? room : rem_clip;
`else
    assign burst = rem_clip;
`endif
    assign last_burst = (rem_q == CMD_LEN_W'(burst));
    // Burst and inflight only move on accept, so read_o cannot drop once raised.
    assign issue_ok   = (state_q == ISSUE_S) &&
                        ((CNT_W+1)'(inflight_q) + (CNT_W+1)'(burst) <= (CNT_W+1)'(MAX_INFLIGHT));
    assign accept     = issue_ok && !waitrequest_i;
    assign err_now    = cmp_error_i || err_pend_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE_S;
            addr_q     <= '0;
            off_q      <= '0;
            end_off_q  <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            ptrn_q     <= '0;
            rnd_q      <= 1'b0;
            first_q    <= 1'b0;
            inflight_q <= '0;
            seed_cnt_q <= '0;
            err_pend_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            end_off_q  <= end_off_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            ptrn_q     <= ptrn_d;
            rnd_q      <= rnd_d;
            first_q    <= first_d;
            inflight_q <= inflight_d;
            seed_cnt_q <= seed_cnt_d;
            err_pend_q <= err_pend_d;
            done_q     <= done_d;
        end
    end

    // NOTE: every _d gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        off_d      = off_q;
        end_off_d  = end_off_q;
        len_d      = len_q;
        rem_d      = rem_q;
        ptrn_d     = ptrn_q;
        rnd_d      = rnd_q;
        first_d    = first_q;
        seed_cnt_d = seed_cnt_q;
        err_pend_d = err_pend_q;
        done_d     = 1'b0;
        inflight_d = inflight_q + (accept ? CNT_W'(burst) : CNT_W'(0)) - CNT_W'(readdatavalid_i);

        unique case (state_q)
            IDLE_S: begin
                if (err_now) begin
                    state_d = ERROR_S;
                end else if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i[BA_W-1:OFF_W];
                    off_d   = cmd_addr_i[OFF_W-1:0];
                    len_d   = cmd_len_i;
                    ptrn_d  = cmd_ptrn_i;
                    rnd_d   = cmd_rnd_i;
                    if (cmd_len_i == '0) done_d  = 1'b1;
                    else                 state_d = CALC_S;
                end
            end
            CALC_S: begin
                if (err_now) begin
                    state_d = ERROR_S;
                end else begin
                    rem_d     = total_words;
                    end_off_d = last_byte[OFF_W-1:0];
                    first_d   = 1'b1;
                    state_d   = ISSUE_S;
                end
            end
            ISSUE_S: begin
                if (accept) begin
                    addr_d  = addr_q + AMM_ADDR_W'(burst);
                    rem_d   = rem_q - CMD_LEN_W'(burst);
                    first_d = 1'b0;
                    if (err_now) begin
                        err_pend_d = 1'b0;
                        state_d    = ERROR_S;
                    end else if (last_burst) begin
                        done_d  = 1'b1;
                        state_d = IDLE_S;
                    end else if (rnd_q) begin
                        seed_cnt_d = burst;
                        state_d    = SEED_S;
                    end
                end else if (err_now) begin
                    // A posted read must still complete, so remember the error until accept.
                    if (issue_ok) err_pend_d = 1'b1;
                    else          state_d    = ERROR_S;
                end
            end
            SEED_S: begin
                if (err_now) begin
                    state_d = ERROR_S;
                end else begin
                    ptrn_d     = {ptrn_q[6:0], ptrn_q[7] ^ ptrn_q[5] ^ ptrn_q[4] ^ ptrn_q[3]};
                    seed_cnt_d = seed_cnt_q - AMM_BURST_W'(1);
                    if (seed_cnt_q == AMM_BURST_W'(1)) state_d = ISSUE_S;
                end
            end
            ERROR_S: ;
            default: state_d = IDLE_S;
        endcase

        if (test_start_i) begin
            state_d    = IDLE_S;
            rem_d      = '0;
            inflight_d = '0;
            seed_cnt_d = '0;
            err_pend_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_comb begin
        cmd_ready_o      = (state_q == IDLE_S);
        busy_o           = (state_q != IDLE_S);
        done_o           = done_q;
        read_o           = issue_ok;
        address_o        = issue_ok ? addr_q : '0;
        burstcount_o     = issue_ok ? burst : '0;
        cmp_en_o         = accept && !err_now;
        cmp_start_addr_o = '0;
        cmp_words_cnt_o  = '0;
        cmp_start_off_o  = '0;
        cmp_end_off_o    = '0;
        cmp_ptrn_o       = '0;
        cmp_rnd_o        = 1'b0;
        if (cmp_en_o) begin
            cmp_start_addr_o = addr_q;
            cmp_words_cnt_o  = (AMM_BURST_W-1)'(burst - AMM_BURST_W'(1));
            cmp_start_off_o  = first_q ? off_q : '0;
            cmp_end_off_o    = last_burst ? end_off_q : OFF_W'(DATA_B - 1);
            cmp_ptrn_o       = ptrn_q;
            cmp_rnd_o        = rnd_q;
        end
    end
endmodule

// File: tb/tb_amm_read_burst_gen.sv
// Directed self-checking bench for amm_read_burst_gen (default 64-bit data, 16-word bursts, 64 in-flight words).
module tb_amm_read_burst_gen;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        test_start_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [33:0] cmd_addr_i;
    logic [31:0] cmd_len_i;
    logic [7:0]  cmd_ptrn_i;
    logic        cmd_rnd_i;
    logic        read_o;
    logic [30:0] address_o;
    logic [4:0]  burstcount_o;
    logic        waitrequest_i;
    logic        readdatavalid_i;
    logic        cmp_en_o;
    logic [30:0] cmp_start_addr_o;
    logic [3:0]  cmp_words_cnt_o;
    logic [2:0]  cmp_start_off_o;
    logic [2:0]  cmp_end_off_o;
    logic [7:0]  cmp_ptrn_o;
    logic        cmp_rnd_o;
    logic        cmp_error_i;
    logic        done_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    amm_read_burst_gen dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .test_start_i     (test_start_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_addr_i       (cmd_addr_i),
        .cmd_len_i        (cmd_len_i),
        .cmd_ptrn_i       (cmd_ptrn_i),
        .cmd_rnd_i        (cmd_rnd_i),
        .read_o           (read_o),
        .address_o        (address_o),
        .burstcount_o     (burstcount_o),
        .waitrequest_i    (waitrequest_i),
        .readdatavalid_i  (readdatavalid_i),
        .cmp_en_o         (cmp_en_o),
        .cmp_start_addr_o (cmp_start_addr_o),
        .cmp_words_cnt_o  (cmp_words_cnt_o),
        .cmp_start_off_o  (cmp_start_off_o),
        .cmp_end_off_o    (cmp_end_off_o),
        .cmp_ptrn_o       (cmp_ptrn_o),
        .cmp_rnd_o        (cmp_rnd_o),
        .cmp_error_i      (cmp_error_i),
        .done_o           (done_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one command in IDLE and returns just after the accept edge.
    task automatic send_cmd(input logic [33:0] addr, input logic [31:0] len,
                            input logic [7:0] ptrn, input logic rnd);
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_ptrn_i  = ptrn;
        cmd_rnd_i   = rnd;
        cmd_valid_i = 1'b1;
        #1;
        check("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain(input int n);
        readdatavalid_i = 1'b1;
        repeat (n) tick();
        readdatavalid_i = 1'b0;
    endtask

    initial begin
        int n;
        rst_i = 1'b1; test_start_i = 1'b0; cmd_valid_i = 1'b0; cmd_addr_i = '0;
        cmd_len_i = '0; cmd_ptrn_i = '0; cmd_rnd_i = 1'b0; waitrequest_i = 1'b0;
        readdatavalid_i = 1'b0; cmp_error_i = 1'b0;
        tick(); tick();
        check("rst_read", 64'(read_o), 64'd0);
        check("rst_cmp_en", 64'(cmp_en_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_address", 64'(address_o), 64'd0);
        rst_i = 1'b0;
        tick();

        // Single full 16-word burst, fixed pattern.
        send_cmd(34'h0, 32'd128, 8'h5A, 1'b0);
        check("calc_busy", 64'(busy_o), 64'd1);
        check("calc_no_read", 64'(read_o), 64'd0);
        tick();
        check("b1_read", 64'(read_o), 64'd1);
        check("b1_addr", 64'(address_o), 64'd0);
        check("b1_bc", 64'(burstcount_o), 64'd16);
        check("b1_cmp_en", 64'(cmp_en_o), 64'd1);
        check("b1_wcnt", 64'(cmp_words_cnt_o), 64'd15);
        check("b1_soff", 64'(cmp_start_off_o), 64'd0);
        check("b1_eoff", 64'(cmp_end_off_o), 64'd7);
        check("b1_ptrn", 64'(cmp_ptrn_o), 64'h5A);
        check("b1_rnd", 64'(cmp_rnd_o), 64'd0);
        tick();
        check("b1_done", 64'(done_o), 64'd1);
        check("b1_idle_read", 64'(read_o), 64'd0);
        tick();
        check("b1_done_pulse", 64'(done_o), 64'd0);
        drain(16);

        // Unaligned short command: offset 3, 10 bytes spans two words.
        send_cmd(34'h3, 32'd10, 8'h11, 1'b0);
        tick();
        check("u_bc", 64'(burstcount_o), 64'd2);
        check("u_addr", 64'(cmp_start_addr_o), 64'd0);
        check("u_wcnt", 64'(cmp_words_cnt_o), 64'd1);
        check("u_soff", 64'(cmp_start_off_o), 64'd3);
        check("u_eoff", 64'(cmp_end_off_o), 64'd4);
        tick();
        check("u_done", 64'(done_o), 64'd1);
        drain(2);

        // Random mode: two bursts separated by 16 LFSR seed cycles.
        send_cmd(34'h0, 32'd256, 8'h01, 1'b1);
        tick();
        check("r1_cmp_en", 64'(cmp_en_o), 64'd1);
        check("r1_ptrn", 64'(cmp_ptrn_o), 64'h01);
        check("r1_rnd", 64'(cmp_rnd_o), 64'd1);
        check("r1_eoff_mid", 64'(cmp_end_off_o), 64'd7);
        tick();
        n = 0;
        while (read_o == 1'b0 && n < 40) begin
            n++;
            tick();
        end
        check("r_seed_cycles", 64'(n), 64'd16);
        check("r2_addr", 64'(address_o), 64'd16);
        check("r2_cmp_en", 64'(cmp_en_o), 64'd1);
        check("r2_ptrn", 64'(cmp_ptrn_o), 64'h4B);
        check("r2_soff", 64'(cmp_start_off_o), 64'd0);
        tick();
        check("r2_done", 64'(done_o), 64'd1);
        drain(32);

        // Waitrequest hold, then in-flight throttling with no returns.
        waitrequest_i = 1'b1;
        send_cmd(34'h0, 32'd128, 8'h00, 1'b0);
        tick();
        check("w_read", 64'(read_o), 64'd1);
        repeat (4) tick();
        check("w_addr_stable", 64'(address_o), 64'd0);
        check("w_bc_stable", 64'(burstcount_o), 64'd16);
        check("w_no_push", 64'(cmp_en_o), 64'd0);
        waitrequest_i = 1'b0;
        #1;
        check("w_push", 64'(cmp_en_o), 64'd1);
        tick();
        for (int k = 1; k < 4; k++) begin
            send_cmd(34'(k * 128), 32'd128, 8'h00, 1'b0);
            tick();
            check("t_accept", 64'(cmp_en_o), 64'd1);
            tick();
        end
        send_cmd(34'd512, 32'd128, 8'h00, 1'b0);
        tick();
        check("t_blocked", 64'(read_o), 64'd0);
        for (int i = 0; i < 16; i++) begin
            readdatavalid_i = 1'b1;
            #1;
            if (i == 15) check("t_blocked_49", 64'(read_o), 64'd0);
            tick();
        end
        readdatavalid_i = 1'b0;
        #1;
        check("t_read_48", 64'(read_o), 64'd1);
        check("t_addr", 64'(address_o), 64'd64);
        check("t_cmp_en", 64'(cmp_en_o), 64'd1);
        tick();
        drain(64);

        // Compare error while the read is stalled.
        waitrequest_i = 1'b1;
        send_cmd(34'h0, 32'd128, 8'h00, 1'b0);
        tick();
        cmp_error_i = 1'b1;
        #1;
        check("e_read", 64'(read_o), 64'd1);
        tick();
        cmp_error_i = 1'b0;
        #1;
        check("e_hold", 64'(read_o), 64'd1);
        waitrequest_i = 1'b0;
        #1;
        check("e_accept_read", 64'(read_o), 64'd1);
        check("e_no_push", 64'(cmp_en_o), 64'd0);
        tick();
        check("e_read_off", 64'(read_o), 64'd0);
        check("e_not_ready", 64'(cmd_ready_o), 64'd0);
        check("e_busy", 64'(busy_o), 64'd1);
        check("e_no_done", 64'(done_o), 64'd0);
        drain(16);
        check("e_still_err", 64'(cmd_ready_o), 64'd0);
        test_start_i = 1'b1;
        tick();
        test_start_i = 1'b0;
        #1;
        check("ts_ready", 64'(cmd_ready_o), 64'd1);
        check("ts_busy", 64'(busy_o), 64'd0);

        // Zero-length command.
        send_cmd(34'h40, 32'd0, 8'h00, 1'b0);
        check("z_done", 64'(done_o), 64'd1);
        check("z_read", 64'(read_o), 64'd0);
        check("z_cmp_en", 64'(cmp_en_o), 64'd0);
        check("z_busy", 64'(busy_o), 64'd0);
        tick();
        check("z_done_pulse", 64'(done_o), 64'd0);

        // Word 12, 16 words: alignment splits only when enabled.
        send_cmd(34'd96, 32'd128, 8'h33, 1'b0);
        tick();
        check("a_addr", 64'(address_o), 64'd12);
`ifdef BURST_ALIGN_EN
        check("a_bc1", 64'(burstcount_o), 64'd4);
        tick();
        check("a_addr2", 64'(address_o), 64'd16);
        check("a_bc2", 64'(burstcount_o), 64'd12);
        check("a_soff2", 64'(cmp_start_off_o), 64'd0);
`else
        check("a_bc", 64'(burstcount_o), 64'd16);
`endif
        tick();
        check("a_done", 64'(done_o), 64'd1);
        drain(16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
